// File: rtl/clock12_time_keeper.sv
// clock12_time_keeper
//   12-hour wall-clock time keeper with a programmable prescaler, a
//   ready/valid time-load port and single-cycle adjust pulses.
//
// Parameters
//   CLK_PER_SEC  clk cycles per second (2 .. 2**26)
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset (time -> 12:00:00 AM)
//   run          1 = prescaler counts and time advances
//   set_valid    time-load request
//   set_isPM     requested AM/PM flag
//   set_hours    requested hours, binary 1..12
//   set_minutes  requested minutes, binary 0..59
//   set_ready    a load request can be accepted this cycle
//   set_err      one-cycle pulse: accepted request was out of range
//   adj_min      single-cycle pulse: minutes + 1, no carry into hours
//   adj_hour     single-cycle pulse: hour advance (11 -> 12 flips AM/PM)
//   isPM         current AM/PM flag
//   hours        current hours, 1..12
//   minutes      current minutes, 0..59
//   seconds      current seconds, 0..59
//   sec_pulse    one-cycle pulse on every seconds advance
//
// State | meaning
// ------+-------------------------------------------------------------
// RUN   | normal timekeeping; load requests, adjusts and ticks honored
// LOAD  | one cycle; captured set_* values are written to the time

module clock12_time_keeper #(
   parameter int CLK_PER_SEC = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       set_valid,
   input  logic       set_isPM,
   input  logic [3:0] set_hours,
   input  logic [5:0] set_minutes,
   output logic       set_ready,
   output logic       set_err,
   input  logic       adj_min,
   input  logic       adj_hour,
   output logic       isPM,
   output logic [3:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       sec_pulse
);

   localparam int            PW         = $clog2(CLK_PER_SEC);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;

   logic          cap_pm;
   logic [3:0]    cap_hours;
   logic [5:0]    cap_minutes;

   logic          tick;
   logic          set_accept;
   logic          set_in_range;
   logic [PW-1:0] presc_next;
   logic [3:0]    hours_adv;
   logic          pm_adv;
   logic [5:0]    min_inc;
   logic [5:0]    sec_inc;

   always_comb begin
      tick         = 1'b0;
      set_accept   = 1'b0;
      set_in_range = 1'b0;
      presc_next   = presc;
      hours_adv    = hours;
      pm_adv       = isPM;
      min_inc      = minutes;
      sec_inc      = seconds;

      if (presc == PRESC_LAST) begin
         presc_next = '0;
      end else begin
         presc_next = presc + PW'(1);
      end

      tick         = (state == RUN) && run && (presc == PRESC_LAST);
      set_accept   = set_valid && set_ready;
      set_in_range = (set_hours != 4'd0) && (set_hours <= 4'd12) &&
                     (set_minutes <= 6'd59);

      // 12 -> 1 keeps the meridiem; 11 -> 12 is where AM/PM flips.
      if (hours == 4'd12) begin
         hours_adv = 4'd1;
      end else begin
         hours_adv = hours + 4'd1;
      end
      if (hours == 4'd11) begin
         pm_adv = ~isPM;
      end

      min_inc = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
      sec_inc = (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         presc       <= '0;
         cap_pm      <= 1'b0;
         cap_hours   <= 4'd12;
         cap_minutes <= 6'd0;
         isPM        <= 1'b0;
         hours       <= 4'd12;
         minutes     <= 6'd0;
         seconds     <= 6'd0;
         set_ready   <= 1'b1;
         set_err     <= 1'b0;
         sec_pulse   <= 1'b0;
      end else begin
         set_err   <= 1'b0;
         sec_pulse <= 1'b0;

         case (state)
            RUN: begin
               // The prescaler keeps its cadence even when the tick's time
               // update loses to a higher-priority event, so a dropped
               // tick is never replayed on the following cycle.
               if (run) begin
                  presc <= presc_next;
               end

               if (set_accept) begin
                  if (set_in_range) begin
                     state       <= LOAD;
                     set_ready   <= 1'b0;
                     cap_pm      <= set_isPM;
                     cap_hours   <= set_hours;
                     cap_minutes <= set_minutes;
                  end else begin
                     set_err <= 1'b1;
                  end
               end else if (adj_hour) begin
                  hours <= hours_adv;
                  isPM  <= pm_adv;
               end else if (adj_min) begin
                  minutes <= min_inc;
               end else if (tick) begin
                  sec_pulse <= 1'b1;
                  seconds   <= sec_inc;
                  if (seconds == 6'd59) begin
                     minutes <= min_inc;
                     if (minutes == 6'd59) begin
                        hours <= hours_adv;
                        isPM  <= pm_adv;
                     end
                  end
               end
            end

            LOAD: begin
               state     <= RUN;
               set_ready <= 1'b1;
               isPM      <= cap_pm;
               hours     <= cap_hours;
               minutes   <= cap_minutes;
               seconds   <= 6'd0;
               presc     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock12_time_keeper.sv
module tb_clock12_time_keeper;

   localparam int CPS = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       set_valid = 1'b0;
   logic       set_isPM = 1'b0;
   logic [3:0] set_hours = 4'd0;
   logic [5:0] set_minutes = 6'd0;
   logic       adj_min = 1'b0;
   logic       adj_hour = 1'b0;
   logic       set_ready;
   logic       set_err;
   logic       isPM;
   logic [3:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       sec_pulse;

   int tests_run = 0;
   int tests_failed = 0;
   int pulse_cnt = 0;

   logic [16:0] exp_q[$];
   logic [16:0] now_t;

   clock12_time_keeper #(.CLK_PER_SEC(CPS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .set_valid  (set_valid),
      .set_isPM   (set_isPM),
      .set_hours  (set_hours),
      .set_minutes(set_minutes),
      .set_ready  (set_ready),
      .set_err    (set_err),
      .adj_min    (adj_min),
      .adj_hour   (adj_hour),
      .isPM       (isPM),
      .hours      (hours),
      .minutes    (minutes),
      .seconds    (seconds),
      .sec_pulse  (sec_pulse)
   );

   always #5 clk = ~clk;

   assign now_t = {isPM, hours, minutes, seconds};

   always @(negedge clk) begin
      if (rst_n && sec_pulse) pulse_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // {isPM, hours, minutes, seconds}
   function automatic logic [16:0] mk(input logic pm, input logic [3:0] h,
                                      input logic [5:0] m, input logic [5:0] s);
      return {pm, h, m, s};
   endfunction

   function automatic logic [16:0] model_hour(input logic [16:0] t);
      logic       pm;
      logic [3:0] h;
      pm = t[16];
      h  = t[15:12];
      if (h == 4'd12) h = 4'd1;
      else if (h == 4'd11) begin
         h  = 4'd12;
         pm = ~pm;
      end else h = h + 4'd1;
      return {pm, h, t[11:0]};
   endfunction

   function automatic logic [16:0] model_tick(input logic [16:0] t);
      logic [16:0] r;
      r = t;
      if (t[5:0] != 6'd59) begin
         r[5:0] = t[5:0] + 6'd1;
      end else begin
         r[5:0] = 6'd0;
         if (t[11:6] != 6'd59) begin
            r[11:6] = t[11:6] + 6'd1;
         end else begin
            r[11:6] = 6'd0;
            r = model_hour(r);
         end
      end
      return r;
   endfunction

   task automatic do_load(input logic pm, input logic [3:0] h, input logic [5:0] m);
      @(negedge clk);
      set_valid   = 1'b1;
      set_isPM    = pm;
      set_hours   = h;
      set_minutes = m;
      @(negedge clk);
      set_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int c;
      @(negedge clk);
      tests_run++;
      if (now_t !== mk(1'b0, 4'd12, 6'd0, 6'd0)) begin
         tests_failed++;
         $display("FAIL reset_time: got %h expected %h", now_t, mk(1'b0, 4'd12, 6'd0, 6'd0));
      end
      tests_run++;
      if ({set_ready, set_err, sec_pulse} !== 3'b100) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b expected 100", {set_ready, set_err, sec_pulse});
      end
      run   = 1'b1;
      rst_n = 1'b1;
      c = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (sec_pulse) begin
            c = i;
            break;
         end
      end
      tests_run++;
      if (c != CPS) begin
         tests_failed++;
         $display("FAIL first_tick_latency: got %0d expected %0d", c, CPS);
      end
      run = 1'b0;
      exp_q.push_back(mk(1'b0, 4'd12, 6'd0, 6'd1));
      tests_run++;
      begin
         logic [16:0] e;
         e = exp_q.pop_front();
         if (now_t !== e) begin
            tests_failed++;
            $display("FAIL first_tick_time: got %h expected %h", now_t, e);
         end
      end
   endtask

   task automatic test_rollover();
      logic [16:0] model;
      logic [16:0] e;
      int          p0;
      bit          found;
      do_load(1'b1, 4'd11, 6'd59);
      tests_run++;
      if (now_t !== mk(1'b1, 4'd11, 6'd59, 6'd0)) begin
         tests_failed++;
         $display("FAIL rollover_load: got %h expected %h", now_t, mk(1'b1, 4'd11, 6'd59, 6'd0));
      end
      #1;
      p0 = pulse_cnt;
      model = mk(1'b1, 4'd11, 6'd59, 6'd0);
      run = 1'b1;
      for (int i = 0; i < 60; i++) begin
         model = model_tick(model);
         exp_q.push_back(model);
         found = 1'b0;
         for (int c = 0; c < 3 * CPS; c++) begin
            @(negedge clk);
            if (sec_pulse) begin
               found = 1'b1;
               break;
            end
         end
         e = exp_q.pop_front();
         tests_run++;
         if (!found) begin
            tests_failed++;
            $display("FAIL rollover_tick[%0d]: no sec_pulse, expected time %h", i, e);
         end else if (now_t !== e) begin
            tests_failed++;
            $display("FAIL rollover_tick[%0d]: got %h expected %h", i, now_t, e);
         end
      end
      run = 1'b0;
      #1;
      tests_run++;
      if (pulse_cnt - p0 != 60) begin
         tests_failed++;
         $display("FAIL rollover_pulse_count: got %0d expected 60", pulse_cnt - p0);
      end
      tests_run++;
      if (now_t !== mk(1'b0, 4'd12, 6'd0, 6'd0) || isPM !== 1'b0) begin
         tests_failed++;
         $display("FAIL rollover_final: got %h expected %h", now_t, mk(1'b0, 4'd12, 6'd0, 6'd0));
      end
   endtask

   task automatic test_out_of_range();
      logic [16:0] base;
      logic [3:0]  hv[3];
      logic [5:0]  mv[3];
      hv[0] = 4'd13; mv[0] = 6'd10;
      hv[1] = 4'd0;  mv[1] = 6'd10;
      hv[2] = 4'd5;  mv[2] = 6'd60;
      run = 1'b0;
      @(negedge clk);
      base = mk(1'b0, 4'd12, 6'd0, 6'd0);
      for (int r = 0; r < 3; r++) begin
         tests_run++;
         if (set_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_ready_before[%0d]: got %b expected 1", r, set_ready);
         end
         set_valid   = 1'b1;
         set_isPM    = 1'b1;
         set_hours   = hv[r];
         set_minutes = mv[r];
         @(negedge clk);
         set_valid = 1'b0;
         tests_run++;
         if (set_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_err[%0d]: got %b expected 1", r, set_err);
         end
         tests_run++;
         if (set_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_ready[%0d]: got %b expected 1", r, set_ready);
         end
         tests_run++;
         if (now_t !== base) begin
            tests_failed++;
            $display("FAIL oor_time[%0d]: got %h expected %h", r, now_t, base);
         end
         @(negedge clk);
         tests_run++;
         if (set_err !== 1'b0 || now_t !== base) begin
            tests_failed++;
            $display("FAIL oor_err_once[%0d]: err %b time %h expected err 0 time %h",
                     r, set_err, now_t, base);
         end
      end
   endtask

   task automatic test_load_timing();
      int          c;
      logic [16:0] e;
      run = 1'b0;
      do_load(1'b1, 4'd12, 6'd59);
      tests_run++;
      if (now_t !== mk(1'b1, 4'd12, 6'd59, 6'd0)) begin
         tests_failed++;
         $display("FAIL load_12_59: got %h expected %h", now_t, mk(1'b1, 4'd12, 6'd59, 6'd0));
      end
      run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      set_valid   = 1'b1;
      set_isPM    = 1'b0;
      set_hours   = 4'd7;
      set_minutes = 6'd30;
      @(negedge clk);
      set_valid   = 1'b0;
      set_hours   = 4'd9;
      set_minutes = 6'd5;
      tests_run++;
      if (set_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_ready_low: got %b expected 0", set_ready);
      end
      @(negedge clk);
      tests_run++;
      if (set_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL load_ready_back: got %b expected 1", set_ready);
      end
      tests_run++;
      if (now_t !== mk(1'b0, 4'd7, 6'd30, 6'd0)) begin
         tests_failed++;
         $display("FAIL load_value: got %h expected %h", now_t, mk(1'b0, 4'd7, 6'd30, 6'd0));
      end
      exp_q.push_back(mk(1'b0, 4'd7, 6'd30, 6'd1));
      c = 0;
      for (int i = 1; i <= 2 * CPS; i++) begin
         @(negedge clk);
         if (sec_pulse) begin
            c = i;
            break;
         end
      end
      run = 1'b0;
      tests_run++;
      if (c != CPS) begin
         tests_failed++;
         $display("FAIL load_tick_latency: got %0d expected %0d", c, CPS);
      end
      e = exp_q.pop_front();
      tests_run++;
      if (now_t !== e) begin
         tests_failed++;
         $display("FAIL load_first_tick: got %h expected %h", now_t, e);
      end
   endtask

   task automatic test_simultaneous();
      logic [16:0] model;
      logic [16:0] e;
      bit          found;
      int          c;
      run = 1'b0;
      do_load(1'b0, 4'd2, 6'd0);
      run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      set_valid   = 1'b1;
      set_isPM    = 1'b0;
      set_hours   = 4'd10;
      set_minutes = 6'd59;
      @(negedge clk);
      set_valid = 1'b0;
      tests_run++;
      if (sec_pulse !== 1'b0 || now_t !== mk(1'b0, 4'd2, 6'd0, 6'd0)) begin
         tests_failed++;
         $display("FAIL sim_load_wins: pulse %b time %h expected pulse 0 time %h",
                  sec_pulse, now_t, mk(1'b0, 4'd2, 6'd0, 6'd0));
      end
      @(negedge clk);
      tests_run++;
      if (now_t !== mk(1'b0, 4'd10, 6'd59, 6'd0) || sec_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL sim_loaded: pulse %b time %h expected pulse 0 time %h",
                  sec_pulse, now_t, mk(1'b0, 4'd10, 6'd59, 6'd0));
      end
      model = mk(1'b0, 4'd10, 6'd59, 6'd0);
      for (int i = 0; i < 59; i++) begin
         model = model_tick(model);
         exp_q.push_back(model);
         found = 1'b0;
         for (int k = 0; k < 3 * CPS; k++) begin
            @(negedge clk);
            if (sec_pulse) begin
               found = 1'b1;
               break;
            end
         end
         e = exp_q.pop_front();
         tests_run++;
         if (!found) begin
            tests_failed++;
            $display("FAIL sim_tick[%0d]: no sec_pulse, expected time %h", i, e);
         end else if (now_t !== e) begin
            tests_failed++;
            $display("FAIL sim_tick[%0d]: got %h expected %h", i, now_t, e);
         end
      end
      for (int k = 0; k < CPS - 1; k++) @(negedge clk);
      adj_min = 1'b1;
      @(negedge clk);
      adj_min = 1'b0;
      tests_run++;
      if (now_t !== mk(1'b0, 4'd10, 6'd0, 6'd59) || sec_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL sim_adj_wins: pulse %b time %h expected pulse 0 time %h",
                  sec_pulse, now_t, mk(1'b0, 4'd10, 6'd0, 6'd59));
      end
      exp_q.push_back(mk(1'b0, 4'd10, 6'd1, 6'd0));
      c = 0;
      for (int i = 1; i <= 2 * CPS; i++) begin
         @(negedge clk);
         if (sec_pulse) begin
            c = i;
            break;
         end
      end
      run = 1'b0;
      tests_run++;
      if (c != CPS) begin
         tests_failed++;
         $display("FAIL sim_no_replay: next tick after %0d cycles expected %0d", c, CPS);
      end
      e = exp_q.pop_front();
      tests_run++;
      if (now_t !== e) begin
         tests_failed++;
         $display("FAIL sim_after_drop: got %h expected %h", now_t, e);
      end
   endtask

   task automatic test_adjust();
      int p0;
      run = 1'b0;
      do_load(1'b0, 4'd11, 6'd0);
      adj_hour = 1'b1;
      @(negedge clk);
      adj_hour = 1'b0;
      tests_run++;
      if (now_t !== mk(1'b1, 4'd12, 6'd0, 6'd0)) begin
         tests_failed++;
         $display("FAIL adj_hour_11_12: got %h expected %h", now_t, mk(1'b1, 4'd12, 6'd0, 6'd0));
      end
      adj_hour = 1'b1;
      @(negedge clk);
      adj_hour = 1'b0;
      tests_run++;
      if (now_t !== mk(1'b1, 4'd1, 6'd0, 6'd0)) begin
         tests_failed++;
         $display("FAIL adj_hour_12_1: got %h expected %h", now_t, mk(1'b1, 4'd1, 6'd0, 6'd0));
      end
      do_load(1'b1, 4'd1, 6'd59);
      adj_min = 1'b1;
      @(negedge clk);
      adj_min = 1'b0;
      tests_run++;
      if (now_t !== mk(1'b1, 4'd1, 6'd0, 6'd0)) begin
         tests_failed++;
         $display("FAIL adj_min_wrap: got %h expected %h", now_t, mk(1'b1, 4'd1, 6'd0, 6'd0));
      end
      #1;
      p0 = pulse_cnt;
      for (int k = 0; k < 4 * CPS; k++) @(negedge clk);
      #1;
      tests_run++;
      if (pulse_cnt != p0 || now_t !== mk(1'b1, 4'd1, 6'd0, 6'd0)) begin
         tests_failed++;
         $display("FAIL adj_run0_frozen: pulses %0d time %h expected pulses 0 time %h",
                  pulse_cnt - p0, now_t, mk(1'b1, 4'd1, 6'd0, 6'd0));
      end
   endtask

   task automatic test_reset_mid_load();
      run = 1'b0;
      @(negedge clk);
      set_valid   = 1'b1;
      set_isPM    = 1'b1;
      set_hours   = 4'd5;
      set_minutes = 6'd45;
      @(negedge clk);
      set_valid = 1'b0;
      tests_run++;
      if (set_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_in_load_state: set_ready %b expected 0", set_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (now_t !== mk(1'b0, 4'd12, 6'd0, 6'd0) || set_ready !== 1'b1 ||
          set_err !== 1'b0 || sec_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_async: time %h ready %b err %b pulse %b expected time %h ready 1 err 0 pulse 0",
                  now_t, set_ready, set_err, sec_pulse, mk(1'b0, 4'd12, 6'd0, 6'd0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (now_t !== mk(1'b0, 4'd12, 6'd0, 6'd0) || set_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_no_load: time %h ready %b expected time %h ready 1",
                  now_t, set_ready, mk(1'b0, 4'd12, 6'd0, 6'd0));
      end
   endtask

   initial begin
      test_reset();
      test_rollover();
      test_out_of_range();
      test_load_timing();
      test_simultaneous();
      test_adjust();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/clock12_time_keeper.md
CLOCK12_TIME_KEEPER -- requirements
Module: clock12_time_keeper

Interface
REQ-001 Parameter CLK_PER_SEC, default 50000000, clock cycles per second; legal range 2..2^26.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  1 = timekeeping advances; 0 = prescaler and time frozen.
REQ-005 set_valid  input  1  time-load request.
REQ-006 set_isPM / set_hours / set_minutes  input  1 / 4 / 6  load values, binary.
REQ-007 set_ready  output  1  load request can be accepted this cycle.
REQ-008 set_err  output  1  one-cycle pulse: accepted request rejected as out of range.
REQ-009 adj_min / adj_hour  input  1 / 1  single-cycle increment pulses, synchronous to clk.
REQ-010 isPM / hours / minutes / seconds  output  1 / 4 / 6 / 6  current 12-hour time, binary, registered; hours 1..12, minutes and seconds 0..59.
REQ-011 sec_pulse  output  1  one-cycle pulse on every seconds advance.

Function
REQ-012 Prescaler counts 0..CLK_PER_SEC-1 while run=1 in state RUN; a tick occurs in the cycle it equals CLK_PER_SEC-1, when it wraps to 0.
REQ-013 Tick: seconds+1; seconds 59 -> 0 carries into minutes; sec_pulse=1 in the cycle after the tick edge, when the outputs change.
REQ-014 Minute carry: minutes+1; minutes 59 -> 0 carries into hours.
REQ-015 Hour advance: 11 -> 12 toggles isPM; 12 -> 1 leaves isPM unchanged; otherwise hours+1.
REQ-016 Full rollover: 11:59:59 PM + tick -> 12:00:00 AM; 11:59:59 AM + tick -> 12:00:00 PM.
REQ-017 FSM states: RUN, LOAD.
- RUN: set_ready=1.
- LOAD: set_ready=0; lasts exactly one cycle, then returns to RUN.
REQ-018 Acceptance: a request is accepted when set_valid=1 and set_ready=1 on the same edge.
- In range (hours 1..12 and minutes 0..59): FSM -> LOAD.
- Out of range: state unchanged, time unchanged, set_err=1 for the next cycle.
REQ-019 On entering LOAD, the next edge loads the outputs:
- isPM, hours, minutes = the captured set_* values.
- seconds=0; prescaler=0.
- set_* values are captured at the acceptance edge; later changes to set_* are ignored.
REQ-020 In LOAD, ticks and adj pulses are discarded; prescaler does not count.
REQ-021 adj_min in RUN: minutes+1, 59 -> 0 with no hour carry; seconds and prescaler unchanged.
REQ-022 adj_hour in RUN: hour advance per REQ-015, including the isPM toggle at 11 -> 12.
REQ-023 Simultaneous events in one cycle, priority order: accepted set_valid > adj_hour > adj_min > tick.
- Lower-priority events in that cycle are dropped; a dropped tick is not replayed.
REQ-024 adj_* pulses are honored regardless of run.
REQ-025 With run=0, the prescaler holds its value; no ticks occur.
REQ-026 Outputs never leave their legal ranges (REQ-010) in any cycle.

Reset
REQ-027 rst_n=0 asynchronously forces:
- isPM=0, hours=12, minutes=0, seconds=0 (12:00:00 AM);
- prescaler=0; state RUN;
- set_ready=1, set_err=0, sec_pulse=0.
REQ-028 Reset asserted during LOAD aborts the load; the captured values are lost.
REQ-029 First tick after release occurs CLK_PER_SEC cycles after the first edge with rst_n=1 and run=1.

Verification
REQ-030 The bench covers these directed scenarios, all with CLK_PER_SEC=4:
- Rollover: load 11:59 PM, run=1 for 60 ticks -> 12:00:00 AM, isPM=0; sec_pulse count = 60.
- Out-of-range load: set_hours=13 (then 0, then set_minutes=60) -> set_err pulses once per request; time unchanged; set_ready stays 1.
- Load timing: load 07:30 AM while prescaler=2 -> set_ready=0 for one cycle; outputs 07:30:00; next tick exactly 4 cycles after load.
- Simultaneous events: set_valid coincident with tick, then adj_min coincident with tick at 10:59:59 -> load wins; then minutes=0, hours=10, seconds=59.
- Adjust pulses: adj_hour at 11 AM -> 12 PM; adj_hour at 12 PM -> 1 PM; adj_min at 59 -> 0 with hour unchanged; run=0 throughout -> seconds frozen.
- Reset mid-operation: rst_n low mid-cycle during LOAD -> outputs immediately 12:00:00 AM, set_ready=1; no load after release.
